// File: rtl/hs_rsp_fetch_if.sv
// Response fetch interface: producer-side RspReq/RspAck/RspAddr/Rsp handshake
// plus the downstream valid/ready word stream.
interface hs_rsp_fetch_if;
  logic        RspReq;
  logic        RspSts;
  logic [4:0]  RspId;
  logic [31:0] Rsp;
  logic        RspAck;
  logic [3:0]  RspAddr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [4:0]  out_id;
  logic        out_sts;

  // Fetch engine side
  modport slave (
    input  RspReq, RspSts, RspId, Rsp, out_ready,
    output RspAck, RspAddr, out_valid, out_data, out_last, out_id, out_sts
  );

  // Producer + downstream consumer side
  modport master (
    output RspReq, RspSts, RspId, Rsp, out_ready,
    input  RspAck, RspAddr, out_valid, out_data, out_last, out_id, out_sts
  );
endinterface

// File: rtl/hs_rsp_fetch.sv
// Host-side response fetch: on RspReq, latch tag/status, read C_RSP_WORDS
// words via RspAddr (one-cycle read latency), stream them through a 2-entry
// FIFO, and pulse RspAck once the last word has been accepted downstream.
module hs_rsp_fetch #(
  parameter int C_RSP_WORDS = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  hs_rsp_fetch_if.slave  bus,
  output logic           busy,
  output logic           proto_err,
  output logic [15:0]    rsp_cnt
);

  localparam int       DATA_W   = 32;
  localparam logic [4:0] LP_WORDS = 5'(C_RSP_WORDS);
  localparam logic [4:0] LP_LASTI = 5'(C_RSP_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ACK, DROP} state_t;

  state_t              r_state;
  logic [4:0]          r_issued;
  logic [3:0]          r_addr;
  logic                r_inflight;
  logic                r_infl_last;
  logic                r_ack;
  logic                r_proto_err;
  logic [15:0]         r_rsp_cnt;
  logic [4:0]          r_id;
  logic                r_sts;

  logic [DATA_W-1:0]   r_fifo_data [2];
  logic [1:0]          r_fifo_last;
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_fifo_cnt;

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic [2:0]          w_occ;

  // Occupancy seen by the issue rule counts the word still in flight and
  // credits a pop happening this same cycle, so the FIFO can never overflow
  // while still sustaining one word per cycle.
  assign w_valid = (r_fifo_cnt != 2'd0);
  assign w_pop   = w_valid & bus.out_ready;
  assign w_push  = r_inflight;
  assign w_occ   = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == FETCH) && (r_issued < LP_WORDS) && (w_occ < 3'd2);

  assign bus.RspAck    = r_ack;
  assign bus.RspAddr   = r_addr;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_last  = w_valid & r_fifo_last[r_rd_ptr];
  assign bus.out_id    = r_id;
  assign bus.out_sts   = r_sts;
  assign busy          = (r_state != IDLE);
  assign proto_err     = r_proto_err;
  assign rsp_cnt       = r_rsp_cnt;

  // Skid FIFO: capture Rsp the cycle after its address was issued, drain from head
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= 2'b00;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_fifo_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.Rsp;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Control FSM: read issue, completion, ack pulse and request hold-off
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_issued    <= 5'd0;
      r_addr      <= 4'd0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_ack       <= 1'b0;
      r_proto_err <= 1'b0;
      r_rsp_cnt   <= 16'd0;
      r_id        <= 5'd0;
      r_sts       <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_issued == LP_LASTI);
      r_ack       <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr   <= 4'd0;
          r_issued <= 5'd0;
          if (bus.RspReq) begin
            r_id    <= bus.RspId;
            r_sts   <= bus.RspSts;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_issue) begin
            r_issued <= r_issued + 5'd1;
            // Address parks on the final word instead of wrapping past it
            if (r_issued != LP_LASTI) begin
              r_addr <= r_addr + 4'd1;
            end
          end
          // Producer withdrew the request early: flag it but finish the transfer
          if (!bus.RspReq) begin
            r_proto_err <= 1'b1;
          end
          if (w_pop && bus.out_last) begin
            r_ack     <= 1'b1;
            r_rsp_cnt <= r_rsp_cnt + 16'd1;
            r_state   <= ACK;
          end
        end
        ACK: begin
          r_state <= DROP;
        end
        DROP: begin
          // A level request still high here is the one just served
          if (!bus.RspReq) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_rsp_fetch.sv
// Testbench for hs_rsp_fetch: table of response transactions with a word
// scoreboard, plus hand sequences for reset-abort, counter wrap and 1-word build.
module tb_hs_rsp_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        busy, proto_err, busy1, proto_err1;
  logic [15:0] rsp_cnt, rsp_cnt1;

  always #5 sys_clk = ~sys_clk;

  hs_rsp_fetch_if bus ();
  hs_rsp_fetch_if bus1 ();

  hs_rsp_fetch #(.C_RSP_WORDS(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus),
    .busy(busy), .proto_err(proto_err), .rsp_cnt(rsp_cnt)
  );

  hs_rsp_fetch #(.C_RSP_WORDS(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus1),
    .busy(busy1), .proto_err(proto_err1), .rsp_cnt(rsp_cnt1)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [4:0]  id;
    logic        sts;
  } exp_t;

  typedef struct {
    logic [4:0]  id;
    logic        sts;
    logic [31:0] base;
    int          mode;      // 0: ready=1, 1: 1,0,0,1 pattern, 2: random
    int          drop_at;   // accepted-word count at which RspReq drops, -1 none
    int          hold;      // cycles RspReq stays high after RspAck
    logic        exp_perr;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[5];
  int          total = 0;
  int          bad = 0;
  int          acc = 0;
  int          acks = 0;
  int          ovf = 0;
  int          resp_base = 0;
  int          rdy_mode = 0;
  int          cyc = 0;
  logic [31:0] base = 32'h0;
  logic [15:0] m_cnt = 16'h0;

  // Memory model: Rsp answers the address presented in the previous cycle
  always @(posedge sys_clk) bus.Rsp <= base + {28'h0, bus.RspAddr};
  always @(posedge sys_clk) bus1.Rsp <= 32'hB000 + {28'h0, bus1.RspAddr};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream consumer, scoreboard and stream invariants
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!sys_rst_n) begin
        prev_stall = 1'b0;
        sbq.delete();
      end else begin
        if (bus.RspAck) acks++;
        if (prev_stall)
          chk("stall_stable", {bus.out_valid, bus.out_last, bus.out_data},
              {1'b1, prev_last, prev_data});
        if (busy)
          chk("addr_ahead", 64'(int'(bus.RspAddr) <= (acc - resp_base) + 2), 64'd1);
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            chk("sb_extra_word", {bus.out_last, bus.out_data}, 64'hDEAD_0000_0000);
          end else begin
            e = sbq.pop_front();
            chk("sb_word", {bus.out_data, bus.out_last, bus.out_id, bus.out_sts}, e);
          end
          acc++;
        end
        if (dut.w_push && (dut.r_fifo_cnt == 2'd2) && !dut.w_pop) ovf++;
        prev_stall = bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end
    end
  end

  task automatic push_exp(input logic [31:0] b, input logic [4:0] id, input logic sts);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.data = b + 32'(i);
      e.last = (i == 15);
      e.id   = id;
      e.sts  = sts;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_ack(input int drop_at, output int lat);
    lat = 0;
    while (bus.RspAck !== 1'b1 && lat < 400) begin
      @(negedge sys_clk);
      lat++;
      if (drop_at >= 0 && (acc - resp_base) >= drop_at) bus.RspReq = 1'b0;
    end
    if (bus.RspAck !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no RspAck within %0d cycles", lat);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy && n < 20);
    chk("return_idle", busy, 1'b0);
  endtask

  task automatic run_rsp(input vec_t v);
    int lat;
    int a0;
    base        = v.base;
    bus.RspId   = v.id;
    bus.RspSts  = v.sts;
    rdy_mode    = v.mode;
    resp_base   = acc;
    a0          = acks;
    push_exp(v.base, v.id, v.sts);
    bus.RspReq  = 1'b1;
    wait_ack(v.drop_at, lat);
    if (v.mode == 0) chk("ack_latency", lat, 19);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge sys_clk);
      chk("holdoff", {bus.out_valid, busy}, 2'b01);
    end
    bus.RspReq = 1'b0;
    wait_idle();
    m_cnt = m_cnt + 16'd1;
    chk("ack_count", acks - a0, 1);
    chk("word_count", acc - resp_base, 16);
    chk("sb_empty", sbq.size(), 0);
    chk("proto_err", proto_err, v.exp_perr);
    chk("rsp_cnt", rsp_cnt, m_cnt);
    chk("tag", {bus.out_id, bus.out_sts}, {v.id, v.sts});
  endtask

  initial begin
    int lat;
    int n;
    int a0;
    bus.RspReq   = 1'b0;
    bus.RspId    = 5'h0;
    bus.RspSts   = 1'b0;
    bus1.RspReq  = 1'b0;
    bus1.RspId   = 5'h0;
    bus1.RspSts  = 1'b0;
    bus1.out_ready = 1'b1;

    vt[0] = '{5'h0A, 1'b1, 32'h1000, 0, -1, 0, 1'b0};
    vt[1] = '{5'h03, 1'b0, 32'h2000, 1, -1, 0, 1'b0};
    vt[2] = '{5'h11, 1'b1, 32'h3000, 2, -1, 5, 1'b0};
    vt[3] = '{5'h1F, 1'b0, 32'h4000, 0, -1, 0, 1'b0};
    vt[4] = '{5'h07, 1'b1, 32'h5000, 1,  4, 0, 1'b1};

    repeat (3) @(negedge sys_clk);
    chk("reset_state", {bus.RspAck, bus.RspAddr, bus.out_valid, bus.out_last, bus.out_id,
                        bus.out_sts, busy, proto_err, bus.out_data, rsp_cnt}, 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int k = 0; k < 5; k++) run_rsp(vt[k]);

    // Reset in the middle of a response with the request still held
    base       = 32'h6000;
    bus.RspId  = 5'h0C;
    bus.RspSts = 1'b0;
    rdy_mode   = 0;
    resp_base  = acc;
    a0         = acks;
    push_exp(32'h6000, 5'h0C, 1'b0);
    bus.RspReq = 1'b1;
    n = 0;
    while ((acc - resp_base) < 8 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("pre_reset_words", 64'((acc - resp_base) >= 8), 64'd1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midreset_state", {bus.RspAck, bus.RspAddr, bus.out_valid, bus.out_last, bus.out_id,
                           bus.out_sts, busy, proto_err, bus.out_data, rsp_cnt}, 64'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    resp_base = acc;
    m_cnt     = 16'd0;
    push_exp(32'h6000, 5'h0C, 1'b0);
    chk("refetch_addr", bus.RspAddr, 4'd0);
    wait_ack(-1, lat);
    chk("refetch_latency", lat, 19);
    bus.RspReq = 1'b0;
    wait_idle();
    m_cnt = 16'd1;
    chk("refetch_words", acc - resp_base, 16);
    chk("refetch_acks", acks - a0, 1);
    chk("refetch_sb_empty", sbq.size(), 0);
    chk("refetch_rsp_cnt", rsp_cnt, m_cnt);
    chk("refetch_perr", proto_err, 1'b0);

    // Counter wrap: preload near the top, then two more responses
    force dut.r_rsp_cnt = 16'hFFFE;
    @(negedge sys_clk);
    release dut.r_rsp_cnt;
    m_cnt = 16'hFFFE;
    run_rsp(vt[0]);
    run_rsp(vt[3]);

    // Single-word build: the only word carries out_last
    bus1.RspId  = 5'h15;
    bus1.RspSts = 1'b1;
    bus1.RspReq = 1'b1;
    n = 0;
    while (bus1.out_valid !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("w1_word", {bus1.out_valid, bus1.out_last, bus1.out_id, bus1.out_sts, bus1.RspAddr,
                    bus1.out_data}, {1'b1, 1'b1, 5'h15, 1'b1, 4'h0, 32'hB000});
    n = 0;
    while (bus1.RspAck !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("w1_ack", bus1.RspAck, 1'b1);
    bus1.RspReq = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("w1_done", {busy1, bus1.out_valid, proto_err1, rsp_cnt1}, {3'b000, 16'd1});

    chk("fifo_overflow", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
